writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Writeback stage that drives the single write port of the 8x18 register file.
//  Merges single-cycle ALU results with out-of-order load returns (buffered in a small FIFO).
//  Keeps a per-register pending-load scoreboard that the issue stage uses for RAW stalls.
//  Sits between EX/MEM and regfile; its registered rf_* outputs connect straight to the write port.
// PARAMETERS
//  WORD_SIZE  18  datapath width
//  REG_COUNT  8   architectural registers (r7 = sp); addresses are 4 bits wide
//  LFIFO_DEPTH 2  load-return FIFO entries (power of 2, >=2)
// PORTS
//  clock           in  1          rising-edge clock
//  reset           in  1          asynchronous, active-high
//  alu_valid       in  1          ALU result present
//  alu_ready       out 1          stage accepts the ALU result this cycle
//  alu_addr        in  4          destination register
//  alu_data        in  WORD_SIZE  result
//  mem_valid       in  1          load data returning
//  mem_ready       out 1          FIFO not full
//  mem_addr        in  4          load destination
//  mem_data        in  WORD_SIZE  load data
//  issue_ld_valid  in  1          a load is being issued (sets pending)
//  issue_ld_addr   in  4          its destination
//  pending_mask    out REG_COUNT  bit i = load to r[i] outstanding
//  rf_write_enable out 1          -> regfile write_enable
//  rf_write_addr   out 4          -> regfile write_addr
//  rf_write_data   out WORD_SIZE  -> regfile write_data
// BEHAVIOUR
//  Reset (async): FIFO empty, scoreboard 0, rf_write_enable/addr/data = 0. mem_ready = 1 and
//   alu_ready = 1 are driven combinationally from the cleared state. A reset mid-operation
//   discards buffered loads.
//  Transfers: ALU when alu_valid&alu_ready; load push when mem_valid&mem_ready.
//  mem_ready = !full, computed from the state at the start of the cycle (no same-cycle bypass
//   on pop).
//  Arbitration per cycle, one write maximum:
//   FIFO full & non-empty -> FIFO head wins, alu_ready=0 (anti-starvation).
//   Otherwise alu_ready=1; ALU wins if alu_valid, else pop FIFO head if non-empty.
//  Latency: the winner appears on rf_* on the next rising edge (registered; 1 cycle).
//   A load pushed into an empty FIFO reaches rf_* no earlier than 2 edges later.
//   rf_write_enable=0 on idle cycles; addr/data then hold their previous values.
//  Address >= REG_COUNT: accepted or popped normally, but rf_write_enable stays 0 (write dropped).
//  FIFO: circular, wrap-around pointers plus count; simultaneous push+pop when not full
//   leaves count unchanged.
//  Scoreboard: issue_ld_valid sets bit[issue_ld_addr]; a FIFO pop written back clears
//   bit[addr]. Same-cycle set and clear of the same bit -> set wins. Issuing a load to a
//   register already pending is illegal: upstream stalls on pending_mask; assertion in sim.
//  Ordering: ALU writes are in order; loads leave in FIFO arrival order.
// STRUCTURE
//  Shared package: WORD_SIZE, REG_COUNT, REG_ADDR_W=4, SP_INDEX=7, wb_entry_t {addr, data}.
//  One sub-module: wb_load_fifo (push/pop/full/empty/count, parameterised depth). Arbiter,
//   scoreboard and output register stay in writeback_stage.
// TESTING
//  1 ALU only: alu r3=0x2AAAA -> next edge rf_we=1, addr 3, data 0x2AAAA; idle -> rf_we=0.
//  2 Contention: ALU r1=5 and mem r2=9 in the same cycle -> r1 written first, r2 on the next
//    cycle; r2 pending bit clears on that edge.
//  3 FIFO full: 2 loads pushed while ALU is busy -> mem_ready=0, alu_ready=0, head drains;
//    mem_ready returns to 1 the next cycle.
//  4 Out-of-range: mem addr 9 -> popped, rf_we stays 0, no scoreboard change.
//  5 Scoreboard race: issue r4 while pending r4 is being cleared -> pending_mask[4] stays 1.
//  6 Async reset mid-burst: assert between edges -> rf_we=0 immediately, mask=0, FIFO empty,
//    post-reset ALU write completes normally.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared types and sizes for the writeback stage: datapath width, register file shape
// and the {addr, data} entry carried through the load-return FIFO.
package writeback_stage_pkg;
  localparam int WORD_SIZE   = 18;
  localparam int REG_COUNT   = 8;
  localparam int REG_ADDR_W  = 4;
  localparam int SP_INDEX    = 7;
  localparam int LFIFO_DEPTH = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WORD_SIZE-1:0]  data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_stage_if.sv
// Bundle of the writeback stage's ALU, load-return, issue and regfile-port signals.
interface writeback_stage_if;
  import writeback_stage_pkg::*;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // ready never depends on valid within the same cycle.
  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [WORD_SIZE-1:0]  alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_addr;
  logic [WORD_SIZE-1:0]  mem_data;
  logic                  issue_ld_valid;
  logic [REG_ADDR_W-1:0] issue_ld_addr;
  logic [REG_COUNT-1:0]  pending_mask;
  logic                  rf_write_enable;
  logic [REG_ADDR_W-1:0] rf_write_addr;
  logic [WORD_SIZE-1:0]  rf_write_data;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           issue_ld_valid, issue_ld_addr,
    input  alu_ready, mem_ready, pending_mask, rf_write_enable, rf_write_addr, rf_write_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           issue_ld_valid, issue_ld_addr,
    output alu_ready, mem_ready, pending_mask, rf_write_enable, rf_write_addr, rf_write_data
  );
endinterface

// File: rtl/writeback_stage_load_fifo.sv
// Circular load-return FIFO; caller guarantees no push when full and no pop when empty.
module wb_load_fifo
  import writeback_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  wb_entry_t                  i_push_entry,
  input  logic                       i_pop,
  output wb_entry_t                  o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: arbitrates ALU results against buffered load returns onto the single
// regfile write port and tracks which registers still await a load.
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  writeback_stage_if.slave  wb
);
  localparam int CW = $clog2(LFIFO_DEPTH + 1);

  wb_entry_t             w_head;
  wb_entry_t             w_push_entry;
  wb_entry_t             w_sel;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic                  w_fifo_priority;
  logic                  w_alu_fire;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_write;
  logic                  w_in_range;
  logic [REG_COUNT-1:0]  w_set;
  logic [REG_COUNT-1:0]  w_clr;

  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_addr;
  logic [WORD_SIZE-1:0]  r_rf_data;
  logic [REG_COUNT-1:0]  r_pending;

  // A full FIFO takes the port so a steady ALU stream cannot starve load returns.
  assign w_fifo_priority = w_full & ~w_empty;
  assign w_alu_fire      = wb.alu_valid & ~w_fifo_priority;
  assign w_pop           = w_fifo_priority | (~wb.alu_valid & ~w_empty);
  assign w_push          = wb.mem_valid & ~w_full;
  assign w_push_entry    = '{addr: wb.mem_addr, data: wb.mem_data};
  assign w_write         = w_alu_fire | w_pop;
  assign w_sel           = w_alu_fire ? wb_entry_t'{addr: wb.alu_addr, data: wb.alu_data} : w_head;
  assign w_in_range      = (w_sel.addr < REG_ADDR_W'(REG_COUNT));

  wb_load_fifo #(.DEPTH(LFIFO_DEPTH)) u_load_fifo (
    .i_clk        (clock),
    .i_rst        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count)
  );

  // Out-of-range addresses match no bit, so they neither set nor clear pending state.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (wb.issue_ld_valid && (wb.issue_ld_addr == REG_ADDR_W'(i))) w_set[i] = 1'b1;
      if (w_pop && (w_head.addr == REG_ADDR_W'(i)))                   w_clr[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
      r_pending <= '0;
    end else begin
      r_rf_we <= w_write & w_in_range;
      if (w_write && w_in_range) begin
        r_rf_addr <= w_sel.addr;
        r_rf_data <= w_sel.data;
      end
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  assign wb.alu_ready       = ~w_fifo_priority;
  assign wb.mem_ready       = ~w_full;
  assign wb.pending_mask    = r_pending;
  assign wb.rf_write_enable = r_rf_we;
  assign wb.rf_write_addr   = r_rf_addr;
  assign wb.rf_write_data   = r_rf_data;

  // Re-issuing to a still-pending register is only legal on the cycle its load retires.
  a_no_double_issue: assert property (@(posedge clock) disable iff (reset)
    (r_pending & w_set & ~w_clr) == '0);
  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    w_count <= CW'(LFIFO_DEPTH));
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus a randomized run against a queue model.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  writeback_stage_if wb ();
  writeback_stage dut (.clock(clock), .reset(reset), .wb(wb.slave));

  int n_tests = 0;
  int n_fail  = 0;

  wb_entry_t             mq[$];
  logic [REG_COUNT-1:0]  m_mask;
  logic                  m_we;
  logic [REG_ADDR_W-1:0] m_addr;
  logic [WORD_SIZE-1:0]  m_data;

  task automatic model_reset();
    mq.delete();
    m_mask = '0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One write per edge: a full queue drains first, else ALU, else oldest load.
  task automatic model_edge();
    int        sz;
    bit        full_q;
    bit        alu_go;
    bit        pop_go;
    bit        wr;
    int        a;
    wb_entry_t w;
    sz     = mq.size();
    full_q = (sz == LFIFO_DEPTH);
    alu_go = wb.alu_valid && !full_q;
    pop_go = full_q || (!wb.alu_valid && sz > 0);
    wr     = 1'b0;
    w      = '0;
    if (alu_go) begin
      w.addr = wb.alu_addr;
      w.data = wb.alu_data;
      wr     = 1'b1;
    end else if (pop_go) begin
      w  = mq[0];
      wr = 1'b1;
    end
    if (pop_go) begin
      a = int'(mq[0].addr);
      if (a < REG_COUNT) m_mask[a] = 1'b0;
      void'(mq.pop_front());
    end
    if (wb.mem_valid && sz < LFIFO_DEPTH) mq.push_back('{addr: wb.mem_addr, data: wb.mem_data});
    if (wb.issue_ld_valid) begin
      a = int'(wb.issue_ld_addr);
      if (a < REG_COUNT) m_mask[a] = 1'b1;
    end
    m_we = wr && (int'(w.addr) < REG_COUNT);
    if (m_we) begin
      m_addr = w.addr;
      m_data = w.data;
    end
  endtask

  task automatic apply(input logic av, input logic [3:0] aa, input logic [17:0] ad,
                       input logic mv, input logic [3:0] ma, input logic [17:0] md,
                       input logic iv, input logic [3:0] ia);
    wb.alu_valid      = av;
    wb.alu_addr       = aa;
    wb.alu_data       = ad;
    wb.mem_valid      = mv;
    wb.mem_addr       = ma;
    wb.mem_data       = md;
    wb.issue_ld_valid = iv;
    wb.issue_ld_addr  = ia;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    n_tests++; if (wb.rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", wb.rf_write_enable); end
    n_tests++; if (wb.rf_write_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", wb.rf_write_addr); end
    n_tests++; if (wb.rf_write_data !== 18'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", wb.rf_write_data); end
    n_tests++; if (wb.pending_mask !== 8'h00) begin n_fail++; $display("FAIL reset_mask: got %h want 00", wb.pending_mask); end
    n_tests++; if (wb.alu_ready !== 1'b1 || wb.mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got alu %b mem %b want 1 1", wb.alu_ready, wb.mem_ready); end
  endtask

  task automatic test_alu_only();
    apply(1, 4'd3, 18'h2AAAA, 0, 0, 0, 0, 0);
    tick();
    n_tests++; if ({wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data} !== {1'b1, 4'd3, 18'h2AAAA}) begin n_fail++; $display("FAIL alu_write: got we %b addr %h data %h want 1 3 2aaaa", wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data); end
    idle(1);
    n_tests++; if (wb.rf_write_enable !== 1'b0 || wb.rf_write_addr !== 4'd3) begin n_fail++; $display("FAIL alu_idle: got we %b addr %h want 0 3", wb.rf_write_enable, wb.rf_write_addr); end
  endtask

  task automatic test_contention();
    apply(0, 0, 0, 0, 0, 0, 1, 4'd2);
    tick();
    n_tests++; if (wb.pending_mask !== 8'h04) begin n_fail++; $display("FAIL cont_issue: got %h want 04", wb.pending_mask); end
    apply(1, 4'd1, 18'd5, 1, 4'd2, 18'd9, 0, 0);
    tick();
    n_tests++; if ({wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data, wb.pending_mask} !== {1'b1, 4'd1, 18'd5, 8'h04}) begin n_fail++; $display("FAIL cont_alu_first: got we %b addr %h data %h mask %h want 1 1 5 04", wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data, wb.pending_mask); end
    idle(1);
    n_tests++; if ({wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data, wb.pending_mask} !== {1'b1, 4'd2, 18'd9, 8'h00}) begin n_fail++; $display("FAIL cont_load_second: got we %b addr %h data %h mask %h want 1 2 9 00", wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data, wb.pending_mask); end
  endtask

  task automatic test_fifo_full();
    apply(1, 4'd0, 18'h11, 1, 4'd5, 18'h55, 0, 0);
    tick();
    apply(1, 4'd6, 18'h22, 1, 4'd6, 18'h66, 0, 0);
    tick();
    n_tests++; if (wb.rf_write_addr !== 4'd6 || wb.rf_write_data !== 18'h22) begin n_fail++; $display("FAIL full_alu_b: got addr %h data %h want 6 22", wb.rf_write_addr, wb.rf_write_data); end
    apply(1, 4'd2, 18'h33, 0, 0, 0, 0, 0);
    n_tests++; if (wb.mem_ready !== 1'b0 || wb.alu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got mem %b alu %b want 0 0", wb.mem_ready, wb.alu_ready); end
    tick();
    n_tests++; if ({wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data} !== {1'b1, 4'd5, 18'h55}) begin n_fail++; $display("FAIL full_head: got we %b addr %h data %h want 1 5 55", wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data); end
    apply(1, 4'd2, 18'h33, 0, 0, 0, 0, 0);
    n_tests++; if (wb.mem_ready !== 1'b1 || wb.alu_ready !== 1'b1) begin n_fail++; $display("FAIL full_recover: got mem %b alu %b want 1 1", wb.mem_ready, wb.alu_ready); end
    tick();
    n_tests++; if (wb.rf_write_addr !== 4'd2 || wb.rf_write_data !== 18'h33) begin n_fail++; $display("FAIL full_alu_c: got addr %h data %h want 2 33", wb.rf_write_addr, wb.rf_write_data); end
    idle(1);
    n_tests++; if (wb.rf_write_addr !== 4'd6 || wb.rf_write_data !== 18'h66) begin n_fail++; $display("FAIL full_tail: got addr %h data %h want 6 66", wb.rf_write_addr, wb.rf_write_data); end
  endtask

  task automatic test_out_of_range();
    apply(1, 4'd1, 18'h123, 0, 0, 0, 1, 4'd0);
    tick();
    apply(0, 0, 0, 1, 4'd9, 18'h3FFFF, 0, 0);
    tick();
    n_tests++; if (wb.rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL oor_push_we: got %b want 0", wb.rf_write_enable); end
    idle(1);
    n_tests++; if ({wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data, wb.pending_mask} !== {1'b0, 4'd1, 18'h123, 8'h01}) begin n_fail++; $display("FAIL oor_pop: got we %b addr %h data %h mask %h want 0 1 123 01", wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data, wb.pending_mask); end
    apply(0, 0, 0, 1, 4'd0, 18'h7, 0, 0);
    tick();
    idle(1);
    n_tests++; if (wb.pending_mask !== 8'h00 || wb.rf_write_addr !== 4'd0) begin n_fail++; $display("FAIL oor_cleanup: got mask %h addr %h want 00 0", wb.pending_mask, wb.rf_write_addr); end
  endtask

  task automatic test_sb_race();
    apply(0, 0, 0, 0, 0, 0, 1, 4'd4);
    tick();
    apply(0, 0, 0, 1, 4'd4, 18'h44, 0, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 1, 4'd4);
    tick();
    n_tests++; if ({wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data, wb.pending_mask} !== {1'b1, 4'd4, 18'h44, 8'h10}) begin n_fail++; $display("FAIL race_set_wins: got we %b addr %h data %h mask %h want 1 4 44 10", wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data, wb.pending_mask); end
    apply(0, 0, 0, 1, 4'd4, 18'h45, 0, 0);
    tick();
    idle(1);
    n_tests++; if (wb.pending_mask !== 8'h00) begin n_fail++; $display("FAIL race_clear: got %h want 00", wb.pending_mask); end
  endtask

  task automatic test_async_reset();
    apply(1, 4'd3, 18'h77, 1, 4'd2, 18'h99, 1, 4'd5);
    tick();
    apply(1, 4'd3, 18'h78, 1, 4'd3, 18'h9A, 0, 0);
    tick();
    n_tests++; if (wb.rf_write_enable !== 1'b1 || wb.pending_mask !== 8'h20 || wb.mem_ready !== 1'b0) begin n_fail++; $display("FAIL arst_pre: got we %b mask %h mem_ready %b want 1 20 0", wb.rf_write_enable, wb.pending_mask, wb.mem_ready); end
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    n_tests++; if ({wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data, wb.pending_mask} !== {1'b0, 4'd0, 18'd0, 8'h00}) begin n_fail++; $display("FAIL arst_now: got we %b addr %h data %h mask %h want 0 0 0 00", wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data, wb.pending_mask); end
    n_tests++; if (wb.mem_ready !== 1'b1 || wb.alu_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got mem %b alu %b want 1 1", wb.mem_ready, wb.alu_ready); end
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    apply(1, 4'd5, 18'h1F, 0, 0, 0, 0, 0);
    tick();
    n_tests++; if ({wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data} !== {1'b1, 4'd5, 18'h1F}) begin n_fail++; $display("FAIL arst_post_alu: got we %b addr %h data %h want 1 5 1f", wb.rf_write_enable, wb.rf_write_addr, wb.rf_write_data); end
    idle(1);
    n_tests++; if (wb.rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL arst_fifo_empty: got we %b want 0", wb.rf_write_enable); end
  endtask

  task automatic test_random();
    logic                  av, mv, iv;
    logic [REG_ADDR_W-1:0] aa, ma, ia;
    logic [WORD_SIZE-1:0]  ad, md;
    logic                  exp_ready;
    for (int c = 0; c < 400; c++) begin
      av = ($urandom_range(0, 3) != 0);
      mv = ($urandom_range(0, 1) != 0);
      aa = REG_ADDR_W'($urandom_range(0, REG_COUNT - 1));
      ma = ($urandom_range(0, 7) == 0) ? REG_ADDR_W'($urandom_range(REG_COUNT, 15))
                                        : REG_ADDR_W'($urandom_range(0, REG_COUNT - 1));
      ad = WORD_SIZE'($urandom());
      md = WORD_SIZE'($urandom());
      ia = REG_ADDR_W'($urandom_range(0, REG_COUNT - 1));
      iv = ($urandom_range(0, 2) == 0) && !m_mask[ia[2:0]];
      apply(av, aa, ad, mv, ma, md, iv, ia);
      exp_ready = (mq.size() != LFIFO_DEPTH);
      n_tests++; if (wb.alu_ready !== exp_ready || wb.mem_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready c%0d: got alu %b mem %b want %b", c, wb.alu_ready, wb.mem_ready, exp_ready); end
      tick();
      n_tests++; if (wb.rf_write_enable !== m_we) begin n_fail++; $display("FAIL rand_we c%0d: got %b want %b", c, wb.rf_write_enable, m_we); end
      n_tests++; if (wb.rf_write_addr !== m_addr || wb.rf_write_data !== m_data) begin n_fail++; $display("FAIL rand_port c%0d: got %h/%h want %h/%h", c, wb.rf_write_addr, wb.rf_write_data, m_addr, m_data); end
      n_tests++; if (wb.pending_mask !== m_mask) begin n_fail++; $display("FAIL rand_mask c%0d: got %h want %h", c, wb.pending_mask, m_mask); end
    end
    idle(3);
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    wb.alu_valid = 1'b0; wb.alu_addr = '0; wb.alu_data = '0;
    wb.mem_valid = 1'b0; wb.mem_addr = '0; wb.mem_data = '0;
    wb.issue_ld_valid = 1'b0; wb.issue_ld_addr = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    test_reset();
    test_alu_only();
    test_contention();
    test_fifo_full();
    test_out_of_range();
    test_sb_race();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
